lshift_sched: RTL and testbench

Controller that shares one 4-bit serial-in/parallel-out left-shift register between two requesters. It accepts parallel words through a valid/ready handshake and grants requesters round-robin. It feeds each word MSB-first into the shift register, captures the register's parallel output once all bits are in, and returns the word with a self-check flag. It sits directly in front of `leftshiftreg`, which shifts on every clock and has no enable, so this block must drive `in` correctly every cycle.

---
 rtl/lshift_sched_pkg.sv | 13 +
 rtl/lshift_sched_if.sv | 28 ++
 rtl/leftshiftreg.sv | 16 +
 rtl/lshift_sched_rr_arbiter2.sv | 23 ++
 rtl/lshift_sched.sv | 100 ++++++++++
 tb/tb_lshift_sched.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/lshift_sched_pkg.sv
// Shared types for the shift-register scheduler: FSM encoding and default width.
// Pure declarations, no logic.
// Not applicable.
package lshift_sched_pkg;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;
endpackage

// File: rtl/lshift_sched_if.sv
// Request/response bundle between requesters and the shift-register scheduler.
// No latency, wires only.
// req_ready is one-hot per requester; rsp side is plain valid/ready.
interface lshift_sched_if
    import lshift_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 2
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_id;
    logic                  rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/leftshiftreg.sv
// Serial-in/parallel-out left shift register, shifts every clock.
// One cycle per bit.
// None: no enable, always shifting.
module leftshiftreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic [WIDTH-1:0] out
);
    always_ff @(posedge clk) begin
        if (rst) out <= '0;
        else     out <= {out[WIDTH-2:0], in};
    end
endmodule

// File: rtl/lshift_sched_rr_arbiter2.sv
// Two-way round-robin arbiter; the caller owns last_grant.
// Combinational, zero latency.
// en low forces no grant.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            // Search starts at the index after the previous winner.
            if (last_grant) begin
                if (req[0])      gnt = 2'b01;
                else if (req[1]) gnt = 2'b10;
            end else begin
                if (req[1])      gnt = 2'b10;
                else if (req[0]) gnt = 2'b01;
            end
        end
    end
endmodule

// File: rtl/lshift_sched.sv
// Shares one left-shift register between two requesters, returning each word with a check flag.
// Response valid WIDTH+1 cycles after the accept edge.
// One word in flight; req_ready low until the response is taken, RESP stalls indefinitely.
module lshift_sched
    import lshift_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = 2
) (
    input  logic             clk,
    input  logic             rst,
    lshift_sched_if.slave    bus,
    output logic             sr_in,
    input  logic [WIDTH-1:0] sr_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(WIDTH - 1);

    state_t           state;
    cnt_t             cnt;
    logic [WIDTH-1:0] word_buf;
    logic             id_q;
    logic             last_grant;
    logic [NREQ-1:0]  gnt;
    logic             win;
    logic [WIDTH-1:0] word;
    logic             rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             rsp_err_q;

    rr_arbiter2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .en         ((state == IDLE) && !rst),
        .gnt        (gnt)
    );

    assign win  = gnt[1];
    assign word = win ? bus.req_data[2*WIDTH-1:WIDTH] : bus.req_data[WIDTH-1:0];

    assign bus.req_ready = gnt;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            word_buf    <= '0;
            id_q        <= 1'b0;
            last_grant  <= 1'b1;
            sr_in       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        word_buf   <= word;
                        id_q       <= win;
                        sr_in      <= word[WIDTH-1];
                        cnt        <= '0;
                        last_grant <= win;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    // LSB has been on sr_in for a full cycle once cnt saturates.
                    if (cnt == LAST) begin
                        sr_in <= 1'b0;
                        state <= CHECK;
                    end else begin
                        cnt   <= cnt + cnt_t'(1);
                        sr_in <= word_buf[LAST - cnt - cnt_t'(1)];
                    end
                end
                CHECK: begin
                    rsp_data_q  <= sr_out;
                    rsp_err_q   <= (sr_out != word_buf);
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lshift_sched.sv
// Bench for lshift_sched wired to leftshiftreg; a transaction-level model predicts grants, serial bits and responses.
module tb_lshift_sched;
    import lshift_sched_pkg::*;
    localparam int W = DEF_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         sr_in;
    logic [W-1:0] sr_q;
    logic [W-1:0] sr_dut;
    logic         fault;

    always #5 clk = ~clk;

    lshift_sched_if #(.WIDTH(W), .NREQ(2)) bus ();

    assign sr_dut = fault ? (sr_q & 4'b1110) : sr_q;

    lshift_sched #(.WIDTH(W), .NREQ(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .sr_in  (sr_in),
        .sr_out (sr_dut)
    );

    leftshiftreg #(.WIDTH(W)) u_sr (
        .clk (clk),
        .rst (rst),
        .in  (sr_in),
        .out (sr_q)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Reference model: one transaction in flight, round-robin preference flips to the other requester after each grant.
    int           prefer = 0;
    bit           busy   = 0;
    int           cur_id;
    int           acc_edge;
    bit           seen_rsp;
    bit           holding;
    logic [W-1:0] cur_word, cur_exp;
    logic [W-1:0] hold_data;
    logic         hold_id, hold_err;
    int           n_acc = 0;
    int           n_rsp = 0;
    int           gq[$];
    int           w_exp;
    int           k;
    logic [1:0]   exp_rdy;

    always @(negedge clk) begin
        if (rst) begin
            chk("req_ready_in_reset", bus.req_ready, 2'b00);
            busy    = 0;
            holding = 0;
            prefer  = 0;
        end else begin
            exp_rdy = 2'b00;
            w_exp   = -1;
            if (!busy) begin
                if (bus.req_valid[prefer])          w_exp = prefer;
                else if (bus.req_valid[1 - prefer]) w_exp = 1 - prefer;
                if (w_exp >= 0) exp_rdy[w_exp] = 1'b1;
                chk("rsp_valid_idle", bus.rsp_valid, 1'b0);
            end
            chk("req_ready", bus.req_ready, exp_rdy);

            if (busy) begin
                k = cyc - acc_edge;
                if (k >= 0 && k <= W)
                    chk("sr_in", sr_in, (k < W) ? cur_word[W-1-k] : 1'b0);
                if (bus.rsp_valid) begin
                    if (!seen_rsp) begin
                        chk("rsp_latency", k, W + 1);
                        seen_rsp = 1;
                    end
                    if (holding) begin
                        chk("stall_data", bus.rsp_data, hold_data);
                        chk("stall_id", bus.rsp_id, hold_id);
                        chk("stall_err", bus.rsp_err, hold_err);
                    end
                    if (bus.rsp_ready) begin
                        chk("rsp_data", bus.rsp_data, cur_exp);
                        chk("rsp_id", bus.rsp_id, cur_id);
                        chk("rsp_err", bus.rsp_err, cur_exp != cur_word);
                        busy    = 0;
                        holding = 0;
                        n_rsp++;
                    end else begin
                        holding   = 1;
                        hold_data = bus.rsp_data;
                        hold_id   = bus.rsp_id;
                        hold_err  = bus.rsp_err;
                    end
                end
            end

            if (w_exp >= 0) begin
                busy     = 1;
                seen_rsp = 0;
                holding  = 0;
                cur_id   = w_exp;
                cur_word = bus.req_data[w_exp*W +: W];
                cur_exp  = fault ? (cur_word & 4'b1110) : cur_word;
                acc_edge = cyc + 1;
                prefer   = 1 - w_exp;
                gq.push_back(w_exp);
                n_acc++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step();
            if (!busy) return;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic wait_accept(input int n0);
        for (int i = 0; i < 60 && n_acc == n0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("accept_timeout", n_acc != n0, 1'b1);
    endtask

    task automatic send(input int id, input logic [W-1:0] word);
        int n0 = n_acc;
        bus.req_data[id*W +: W] = word;
        bus.req_valid[id]       = 1'b1;
        wait_accept(n0);
        step();
        bus.req_valid[id] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n0;
        rst           = 1'b1;
        fault         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) step();
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, 4'h0);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_sr_in", sr_in, 1'b0);
        chk("rst_sr_out", sr_q, 4'h0);
        bus.req_valid = 2'b00;
        step();
        rst = 1'b0;

        // Single word from requester 0.
        send(0, 4'b1010);
        wait_idle(40);

        // Both requesters continuously valid: grants must alternate.
        gq.delete();
        bus.req_data  = {4'hC, 4'h3};
        bus.req_valid = 2'b11;
        repeat (40) step();
        bus.req_valid = 2'b00;
        wait_idle(40);
        chk("alt_grant_count", gq.size() >= 4, 1'b1);
        for (int i = 1; i < gq.size(); i++)
            chk("alt_grant", gq[i], 1 - gq[i-1]);

        // Response stall with both requesters knocking.
        bus.rsp_ready = 1'b0;
        send(0, 4'h9);
        bus.req_valid = 2'b11;
        repeat (W + 12) step();
        chk("stall_rsp_valid", bus.rsp_valid, 1'b1);
        chk("stall_rsp_value", bus.rsp_data, 4'h9);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        wait_idle(10);

        // Reset two cycles into SHIFT discards the word.
        send(0, 4'hF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sr_out", sr_q, 4'h0);
        chk("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
        n0 = n_rsp;
        send(0, 4'h6);
        wait_idle(40);
        chk("post_rst_one_rsp", n_rsp - n0, 1);

        // Stuck-at-0 on the parallel bit 0.
        fault = 1'b1;
        send(0, 4'h5);
        wait_idle(40);
        fault = 1'b0;

        // Short req1 pulse while req0 is in flight must not be granted or disturb priority.
        send(0, 4'h2);
        step();
        bus.req_data[W +: W] = 4'hB;
        bus.req_valid[1]     = 1'b1;
        step();
        bus.req_valid[1] = 1'b0;
        wait_idle(40);
        n0            = n_acc;
        bus.req_data  = {4'h7, 4'h1};
        bus.req_valid = 2'b11;
        wait_accept(n0);
        chk("rr_after_pulse", gq[$], 1);
        step();
        bus.req_valid = 2'b00;
        wait_idle(40);

        // Random traffic, withdrawals, backpressure and occasional resets.
        n0 = n_rsp;
        for (int i = 0; i < 1500; i++) begin
            bus.req_valid = 2'($urandom);
            bus.req_data  = 8'($urandom);
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            rst           = ($urandom_range(0, 199) == 0);
            step();
        end
        rst           = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        wait_idle(40);
        chk("random_rsp_count", (n_rsp - n0) >= 20, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
